fixed_dot_product_seq: RTL and testbench

- Sequencer and accumulator that sits directly upstream of the fixed-point multiplier and also consumes its output.
- Takes a valid/ready stream of operand pairs and issues one start pulse per pair to the multiplier.
- Captures each product when the multiplier's ready pulse arrives, accumulates the products with signed saturation, and presents the dot-product result on a valid/ready output when the pair flagged last has been processed.

---
 rtl/fixed_pkg.sv | 47 ++++
 rtl/fixed_sat_accumulator.sv | 69 ++++++
 rtl/fixed_dot_product_seq.sv | 149 ++++++++++++++
 tb/tb_fixed_dot_product_seq.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared types and signed saturating arithmetic for the fixed-point dot-product sequencer.
// Arithmetic runs on a 64-bit signed carrier, so any DATA_WIDTH below 64 cannot overflow it.
package fixed_pkg;

  localparam int unsigned WideWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } seq_state_e;

  typedef struct packed {
    logic [WideWidth-1:0] sum;
    logic                 ovf;
  } sat_res_t;

  // Largest positive value representable in a width-bit two's-complement word.
  function automatic logic signed [WideWidth-1:0] max_pos(input int unsigned width);
    return (WideWidth'(1) << (width - 1)) - WideWidth'(1);
  endfunction

  function automatic logic signed [WideWidth-1:0] max_neg(input int unsigned width);
    return ~max_pos(width);
  endfunction

  // Operands arrive sign-extended to WideWidth; the result is clamped to the width-bit range.
  function automatic sat_res_t sat_add(input logic signed [WideWidth-1:0] a,
                                       input logic signed [WideWidth-1:0] b,
                                       input int unsigned                 width);
    logic signed [WideWidth-1:0] s;
    sat_res_t                    r;
    s     = a + b;
    r.sum = s;
    r.ovf = 1'b0;
    if (s > max_pos(width)) begin
      r.sum = max_pos(width);
      r.ovf = 1'b1;
    end else if (s < max_neg(width)) begin
      r.sum = max_neg(width);
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_sat_accumulator.sv
// Saturating accumulator with a sticky overflow flag and a saturating term counter.
module fixed_sat_accumulator
  import fixed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TERM_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      en_i,
  input  logic [DATA_WIDTH-1:0]     product_i,
  output logic [DATA_WIDTH-1:0]     acc_o,
  output logic [TERM_CNT_WIDTH-1:0] terms_o,
  output logic                      sat_o
);

  logic [DATA_WIDTH-1:0]     acc_q, acc_d;
  logic [TERM_CNT_WIDTH-1:0] terms_q, terms_d;
  logic                      sat_q, sat_d;

  sat_res_t             add_res;
  logic [WideWidth-1:0] sum_wide;
  logic                 unused_sum_hi;

  always_comb begin
    add_res = sat_add({{(WideWidth - DATA_WIDTH){acc_q[DATA_WIDTH-1]}}, acc_q},
                      {{(WideWidth - DATA_WIDTH){product_i[DATA_WIDTH-1]}}, product_i},
                      DATA_WIDTH);
  end

  assign sum_wide = add_res.sum;
  // After clamping, the upper bits are pure sign extension.
  assign unused_sum_hi = ^sum_wide[WideWidth-1:DATA_WIDTH];

  always_comb begin
    acc_d   = acc_q;
    terms_d = terms_q;
    sat_d   = sat_q;
    if (clear_i) begin
      acc_d   = '0;
      terms_d = '0;
      sat_d   = 1'b0;
    end else if (en_i) begin
      acc_d = sum_wide[DATA_WIDTH-1:0];
      sat_d = sat_q | add_res.ovf;
      if (terms_q != '1) begin
        terms_d = terms_q + TERM_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      terms_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      terms_q <= terms_d;
      sat_q   <= sat_d;
    end
  end

  assign acc_o   = acc_q;
  assign terms_o = terms_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/fixed_dot_product_seq.sv
// Streams operand pairs into an external fixed-point multiplier, one at a time, and
// accumulates the returned products into a saturated dot product with a valid/ready result.
module fixed_dot_product_seq
  import fixed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FRAC_BIT_COUNT = DATA_WIDTH / 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TERM_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     mul_multiplier,
  output logic [DATA_WIDTH-1:0]     mul_multiplicand,
  output logic                      mul_start,
  input  logic [DATA_WIDTH-1:0]     mul_product,
  input  logic                      mul_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [TERM_CNT_WIDTH-1:0] out_terms,
  output logic                      out_sat,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES) + 1;

  // FRAC_BIT_COUNT only documents the multiplier's Q format; the sum is format-agnostic.
  if (DATA_WIDTH < 2 || DATA_WIDTH >= WideWidth || FRAC_BIT_COUNT >= DATA_WIDTH ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fixed_dot_product_seq: unsupported parameter set");
  end

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic                  last_q, last_d;
  logic [TmoWidth-1:0]   tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;
  logic                  start_q, start_d;
  logic                  out_valid_q, out_valid_d;
  logic                  acc_en, acc_clr;
  logic                  out_fire;

  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          opa_d   = in_a;
          opb_d   = in_b;
          last_d  = in_last;
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A product arriving on the final timeout cycle still wins over the abort.
        if (mul_ready) begin
          acc_en  = 1'b1;
          state_d = last_q ? StDone : StIdle;
        end else if (tmo_q == TmoWidth'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
        end
      end
      StDone: begin
        if (out_fire) begin
          acc_clr = 1'b1;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake outputs are registered decodes so they never glitch toward neighbours.
    in_ready_d  = (state_d == StIdle);
    start_d     = (state_d == StIssue);
    out_valid_d = (state_q == StDone) && !out_fire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      opa_q       <= '0;
      opb_q       <= '0;
      last_q      <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
    end
  end

  fixed_sat_accumulator #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TERM_CNT_WIDTH(TERM_CNT_WIDTH)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (acc_clr),
    .en_i     (acc_en),
    .product_i(mul_product),
    .acc_o    (out_data),
    .terms_o  (out_terms),
    .sat_o    (out_sat)
  );

  assign in_ready         = in_ready_q;
  assign mul_multiplier   = opa_q;
  assign mul_multiplicand = opb_q;
  assign mul_start        = start_q;
  assign out_err          = err_q;
  assign out_valid        = out_valid_q;

endmodule

// File: tb/tb_fixed_dot_product_seq.sv
// Bench for fixed_dot_product_seq: Q16.16 multiplier model plus a saturating dot-product model.
module tb_fixed_dot_product_seq;

  localparam int DW = 32;
  localparam int TO = 64;
  localparam int TW = 16;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_a, in_b;
  logic          in_last, in_valid, in_ready;
  logic [DW-1:0] mul_multiplier, mul_multiplicand, mul_product;
  logic          mul_start, mul_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_terms;
  logic          out_sat, out_err, out_valid, out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cnt = 0;
  int acc_cyc[$];

  bit            mul_mute  = 1'b0;
  bit            stray_req = 1'b0;
  bit            pend_v    = 1'b0;
  logic [DW-1:0] pend_p    = '0;

  fixed_dot_product_seq #(
    .DATA_WIDTH    (DW),
    .FRAC_BIT_COUNT(16),
    .TIMEOUT_CYCLES(TO),
    .TERM_CNT_WIDTH(TW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_last         (in_last),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .mul_multiplier  (mul_multiplier),
    .mul_multiplicand(mul_multiplicand),
    .mul_start       (mul_start),
    .mul_product     (mul_product),
    .mul_ready       (mul_ready),
    .out_data        (out_data),
    .out_terms       (out_terms),
    .out_sat         (out_sat),
    .out_err         (out_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mul_start) start_cnt <= start_cnt + 1;

  function automatic logic [DW-1:0] fxmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return DW'(p >>> 16);
  endfunction

  // Multiplier model: sees start at one edge, presents the product for the following edge.
  initial begin
    mul_ready   = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      mul_ready   = pend_v | stray_req;
      mul_product = stray_req ? 32'h1234_5678 : pend_p;
      stray_req   = 1'b0;
      pend_v      = mul_start && !mul_mute;
      pend_p      = fxmul(mul_multiplier, mul_multiplicand);
    end
  end

  // Dot product as a mathematician would compute it, clamping after every term.
  function automatic void ref_dot(input logic [DW-1:0] qa[$], input logic [DW-1:0] qb[$],
                                  output logic [DW-1:0] d, output int t, output bit s);
    longint acc = 0;
    s = 0;
    foreach (qa[i]) begin
      acc += longint'(signed'(fxmul(qa[i], qb[i])));
      if (acc > 64'sd2147483647) begin
        acc = 64'sd2147483647;
        s   = 1;
      end else if (acc < -64'sd2147483648) begin
        acc = -64'sd2147483648;
        s   = 1;
      end
    end
    d = DW'(acc);
    t = qa.size();
  endfunction

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last,
                      output bit ok);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok       = in_ready;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    acc_cyc.push_back(cyc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 300);
    ok = out_valid;
  endtask

  task automatic take(output logic [DW-1:0] d, output logic [TW-1:0] t, output logic s,
                      output logic e);
    d = out_data;
    t = out_terms;
    s = out_sat;
    e = out_err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input logic [DW-1:0] qa[$], input logic [DW-1:0] qb[$],
                         output logic [DW-1:0] d, output logic [TW-1:0] t, output logic s,
                         output logic e, output int lat, output bit ok);
    bit pok;
    ok = 1;
    foreach (qa[i]) begin
      push(qa[i], qb[i], (i == qa.size() - 1), pok);
      ok &= pok;
    end
    wait_valid(lat, pok);
    ok &= pok;
    take(d, t, s, e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, mul_start, out_valid, out_sat, out_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {in_ready, mul_start, out_valid, out_sat, out_err});
    end
    n_tests++;
    if (out_data !== '0 || out_terms !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%0d expected 0/0", out_data, out_terms);
    end
    n_tests++;
    if (mul_multiplier !== '0 || mul_multiplicand !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: got %h/%h expected 0/0", mul_multiplier, mul_multiplicand);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] qa[$], qb[$], d;
    logic [TW-1:0] t;
    logic s, e;
    int lat, s0;
    bit ok;
    qa = '{32'h0001_8000};
    qb = '{32'h0002_0000};
    s0 = start_cnt;
    run_vec(qa, qb, d, t, s, e, lat, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_handshake: got timeout expected response"); end
    n_tests++;
    if (d !== 32'h0003_0000 || t !== 16'd1) begin
      n_fail++;
      $display("FAIL single_result: got %h/%0d expected 00030000/1", d, t);
    end
    n_tests++;
    if (s !== 1'b0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL single_flags: got sat=%b err=%b expected 0/0", s, e);
    end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", lat); end
    n_tests++;
    if (start_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL single_starts: got %0d expected 1", start_cnt - s0);
    end
  endtask

  task automatic test_three();
    logic [DW-1:0] qa[$], qb[$], d;
    logic [TW-1:0] t;
    logic s, e;
    int lat, s0;
    bit ok, pok;
    qa = '{32'h0001_0000, 32'h0002_0000, 32'h0000_4000};
    qb = '{32'h0001_0000, 32'h0000_8000, 32'h0004_0000};
    s0 = start_cnt;
    acc_cyc.delete();
    ok = 1;
    foreach (qa[i]) begin
      push(qa[i], qb[i], (i == 2), pok);
      ok &= pok;
      n_tests++;
      if (in_ready !== 1'b0 || mul_start !== 1'b1) begin
        n_fail++;
        $display("FAIL three_issue_%0d: got ready=%b start=%b expected 0/1", i, in_ready,
                 mul_start);
      end
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || mul_start !== 1'b0) begin
        n_fail++;
        $display("FAIL three_wait_%0d: got ready=%b start=%b expected 0/0", i, in_ready,
                 mul_start);
      end
    end
    wait_valid(lat, pok);
    ok &= pok;
    take(d, t, s, e);
    n_tests++;
    if (!ok || d !== 32'h0003_0000 || t !== 16'd3 || s !== 1'b0) begin
      n_fail++;
      $display("FAIL three_result: got %h/%0d sat=%b ok=%b expected 00030000/3 sat=0", d, t, s,
               ok);
    end
    n_tests++;
    if (start_cnt - s0 !== 3) begin
      n_fail++;
      $display("FAIL three_starts: got %0d expected 3", start_cnt - s0);
    end
    n_tests++;
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      n_fail++;
      $display("FAIL three_throughput: got accept gaps %p expected 3 cycles apart", acc_cyc);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] qa[$], qb[$], d;
    logic [TW-1:0] t;
    logic s, e;
    int lat;
    bit ok;
    qa = '{32'h7FFF_0000, 32'h0002_0000};
    qb = '{32'h0001_0000, 32'h0001_0000};
    run_vec(qa, qb, d, t, s, e, lat, ok);
    n_tests++;
    if (!ok || d !== 32'h7FFF_FFFF || s !== 1'b1 || t !== 16'd2) begin
      n_fail++;
      $display("FAIL sat_pos: got %h sat=%b terms=%0d expected 7fffffff sat=1 terms=2", d, s, t);
    end
    qa = '{32'h8001_0000, 32'hFFFE_0000};
    run_vec(qa, qb, d, t, s, e, lat, ok);
    n_tests++;
    if (!ok || d !== 32'h8000_0000 || s !== 1'b1 || t !== 16'd2) begin
      n_fail++;
      $display("FAIL sat_neg: got %h sat=%b terms=%0d expected 80000000 sat=1 terms=2", d, s, t);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] qa[$], qb[$], d, ed;
    logic [TW-1:0] t;
    logic s, e;
    int lat, et, n;
    bit ok, es;
    logic [DW-1:0] x;
    for (int v = 0; v < 8; v++) begin
      qa.delete();
      qb.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          qa.push_back($urandom());
          qb.push_back($urandom());
        end else begin
          x = $urandom_range(0, 32'h0003_FFFF);
          qa.push_back($urandom_range(0, 1) == 1 ? -x : x);
          x = $urandom_range(0, 32'h0003_FFFF);
          qb.push_back($urandom_range(0, 1) == 1 ? -x : x);
        end
      end
      ref_dot(qa, qb, ed, et, es);
      run_vec(qa, qb, d, t, s, e, lat, ok);
      n_tests++;
      if (!ok || d !== ed || t !== TW'(et) || s !== es || e !== 1'b0 || lat !== 3) begin
        n_fail++;
        $display("FAIL random_%0d: got %h/%0d sat=%b err=%b lat=%0d expected %h/%0d sat=%b err=0 lat=3",
                 v, d, t, s, e, lat, ed, et, es);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic s, e;
    int lat, s0;
    bit ok, pok;
    logic [DW-1:0] snap_d;
    logic [TW-1:0] snap_t;
    push(32'h0001_0000, 32'h0002_0000, 1'b0, ok);
    push(32'h0003_0000, 32'h0001_0000, 1'b1, pok);
    ok &= pok;
    wait_valid(lat, pok);
    ok &= pok;
    snap_d = out_data;
    snap_t = out_terms;
    s0 = start_cnt;
    n_tests++;
    if (!ok || snap_d !== 32'h0005_0000 || snap_t !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_result: got %h/%0d expected 00050000/2", snap_d, snap_t);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      in_a     = $urandom();
      in_b     = $urandom();
      in_last  = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap_d ||
          out_terms !== snap_t || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b rdy=%b %h/%0d expected v=1 rdy=0 %h/%0d", i,
                 out_valid, in_ready, out_data, out_terms, snap_d, snap_t);
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (start_cnt - s0 !== 0) begin
      n_fail++;
      $display("FAIL bp_no_start: got %0d starts expected 0", start_cnt - s0);
    end
    take(d, t, s, e);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_terms !== '0) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b %h/%0d expected v=0 0/0", out_valid, out_data,
               out_terms);
    end
    push(32'h0001_0000, 32'h0003_0000, 1'b1, ok);
    wait_valid(lat, pok);
    ok &= pok;
    take(d, t, s, e);
    n_tests++;
    if (!ok || d !== 32'h0003_0000 || t !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_next_vector: got %h/%0d expected 00030000/1", d, t);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic s, e;
    int lat;
    bit ok, pok;
    mul_mute = 1'b1;
    push(32'h0001_0000, 32'h0001_0000, 1'b0, ok);
    wait_valid(lat, pok);
    ok &= pok;
    n_tests++;
    if (!ok || lat !== TO + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d ok=%b expected %0d", lat, ok, TO + 2);
    end
    take(d, t, s, e);
    mul_mute = 1'b0;
    n_tests++;
    if (e !== 1'b1 || t !== '0 || d !== '0 || s !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_result: got err=%b terms=%0d data=%h sat=%b expected 1/0/0/0", e,
               t, d, s);
    end
    @(negedge clk);
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_terms !== '0 || out_data !== '0 || in_ready !== 1'b1 ||
        out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ready: got v=%b terms=%0d data=%h rdy=%b err=%b expected 0/0/0/1/0",
               out_valid, out_terms, out_data, in_ready, out_err);
    end
    push(32'h0001_0000, 32'h0002_0000, 1'b1, ok);
    wait_valid(lat, pok);
    ok &= pok;
    take(d, t, s, e);
    n_tests++;
    if (!ok || d !== 32'h0002_0000 || t !== 16'd1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_recover: got %h/%0d err=%b expected 00020000/1 err=0", d, t, e);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic s, e;
    int lat;
    bit ok, pok;
    push(32'h0002_0000, 32'h0002_0000, 1'b0, ok);
    mul_mute = 1'b1;
    push(32'h0001_0000, 32'h0001_0000, 1'b1, pok);
    ok &= pok;
    @(negedge clk);
    n_tests++;
    if (!ok || out_data !== 32'h0004_0000 || out_terms !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_precond: got %h/%0d expected 00040000/1", out_data, out_terms);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, mul_start, out_valid, out_sat, out_err} !== 5'b0 || out_data !== '0 ||
        out_terms !== '0 || mul_multiplier !== '0 || mul_multiplicand !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got flags=%b data=%h terms=%0d ops=%h/%h expected all 0",
               {in_ready, mul_start, out_valid, out_sat, out_err}, out_data, out_terms,
               mul_multiplier, mul_multiplicand);
    end
    @(negedge clk);
    reset    = 1'b1;
    mul_mute = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: got rdy=%b v=%b expected 1/0", in_ready, out_valid);
    end
    push(32'h0001_8000, 32'h0002_0000, 1'b1, ok);
    wait_valid(lat, pok);
    ok &= pok;
    take(d, t, s, e);
    n_tests++;
    if (!ok || d !== 32'h0003_0000 || t !== 16'd1 || s !== 1'b0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fresh_vector: got %h/%0d sat=%b err=%b expected 00030000/1/0/0", d, t,
               s, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_saturation();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
